// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Imported by the top; the full-adder cell is type-free and needs nothing from here.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell time-shared across the word by serial_adder.
// Purely combinational: s = a^b^cin, cout = ab | cin(a^b).
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_p;

    assign w_p    = i_a ^ i_b;
    assign o_s    = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// start->done is WIDTH+1 cycles; start is ignored outside IDLE and never queued.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int             CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_cff;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    full_adder u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_cff),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    assign w_last = (r_cnt == LAST_BIT);
    // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
    assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (w_last)  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            RUN:     o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_cff   <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a_sr <= i_a;
                        r_b_sr <= i_b;
                        r_res  <= '0;
                        r_cff  <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_res  <= w_res_nxt;
                    r_cff  <= w_cout;
                    r_cnt  <= r_cnt + 1'b1;
                    // Visible result only moves on the completing edge.
                    if (w_last) begin
                        r_sum   <= w_res_nxt;
                        r_carry <= w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed scenarios plus randomized
// back-to-back additions against an arithmetic reference.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int n_cmp = 0;
    int n_err = 0;

    // Result the DUT should currently be presenting, tracked by the bench.
    logic [W:0] last_res;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_carry (carry)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step into cycle 1 of the new operation.
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, carry, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy/done/carry/sum=%h required 0", {busy, done, carry, sum});
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if ({busy, done, carry, sum} !== '0) begin
                n_err++;
                $display("FAIL reset_idle c%0d: busy/done/carry/sum=%h required 0", c, {busy, done, carry, sum});
            end
        end
        last_res = '0;
    endtask

    task automatic test_basic_wrap();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [W:0]   ve [3];
        va[0] = 8'h3C; vb[0] = 8'h05; ve[0] = 9'h041;
        va[1] = 8'hFF; vb[1] = 8'h01; ve[1] = 9'h100;
        va[2] = 8'hFF; vb[2] = 8'hFF; ve[2] = 9'h1FE;
        for (int i = 0; i < 3; i++) begin
            do_start(va[i], vb[i]);
            for (int c = 1; c <= W; c++) begin
                n_cmp++;
                if ({busy, done, carry, sum} !== {2'b10, last_res}) begin
                    n_err++;
                    $display("FAIL basic_run v%0d c%0d: busy,done,carry,sum=%h required %h",
                             i, c, {busy, done, carry, sum}, {2'b10, last_res});
                end
                tick();
            end
            n_cmp++;
            if ({busy, done, carry, sum} !== {2'b01, ve[i]}) begin
                n_err++;
                $display("FAIL basic_done v%0d: busy,done,carry,sum=%h required %h",
                         i, {busy, done, carry, sum}, {2'b01, ve[i]});
            end
            last_res = ve[i];
            tick();
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_err++;
                $display("FAIL basic_pulse v%0d: busy,done=%b required 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_ignored_start();
        do_start(8'h10, 8'h20);
        for (int c = 1; c <= W; c++) begin
            n_cmp++;
            if ({busy, done, carry, sum} !== {2'b10, last_res}) begin
                n_err++;
                $display("FAIL ign_run c%0d: busy,done,carry,sum=%h required %h",
                         c, {busy, done, carry, sum}, {2'b10, last_res});
            end
            start = (c == 3);
            a     = (c == 3) ? 8'h77 : 8'h10;
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if ({busy, done, carry, sum} !== {2'b01, 9'h030}) begin
            n_err++;
            $display("FAIL ign_done: busy,done,carry,sum=%h required %h", {busy, done, carry, sum}, {2'b01, 9'h030});
        end
        last_res = 9'h030;
        start = 1'b1; a = 8'h77;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, done, carry, sum} !== {2'b00, 9'h030}) begin
            n_err++;
            $display("FAIL ign_not_queued: busy,done,carry,sum=%h required %h", {busy, done, carry, sum}, {2'b00, 9'h030});
        end
        do_start(8'h77, 8'h01);
        for (int c = 1; c <= W; c++) begin
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
                n_err++;
                $display("FAIL ign_rerun c%0d: busy,done=%b required 10", c, {busy, done});
            end
            tick();
        end
        n_cmp++;
        if ({busy, done, carry, sum} !== {2'b01, 9'h078}) begin
            n_err++;
            $display("FAIL ign_redone: busy,done,carry,sum=%h required %h", {busy, done, carry, sum}, {2'b01, 9'h078});
        end
        last_res = 9'h078;
        tick();
    endtask

    task automatic test_reset_mid();
        do_start(8'hAA, 8'h55);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, carry, sum} !== '0) begin
            n_err++;
            $display("FAIL rstmid_state: busy,done,carry,sum=%h required 0", {busy, done, carry, sum});
        end
        rst = 1'b0;
        last_res = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp++;
            if ({busy, done, carry, sum} !== '0) begin
                n_err++;
                $display("FAIL rstmid_quiet c%0d: busy,done,carry,sum=%h required 0", c, {busy, done, carry, sum});
            end
        end
        do_start(8'hAA, 8'h55);
        for (int c = 1; c <= W; c++) begin
            n_cmp++;
            if ({busy, done, carry, sum} !== {2'b10, last_res}) begin
                n_err++;
                $display("FAIL rstmid_run c%0d: busy,done,carry,sum=%h required %h",
                         c, {busy, done, carry, sum}, {2'b10, last_res});
            end
            tick();
        end
        n_cmp++;
        if ({busy, done, carry, sum} !== {2'b01, 9'h0FF}) begin
            n_err++;
            $display("FAIL rstmid_done: busy,done,carry,sum=%h required %h", {busy, done, carry, sum}, {2'b01, 9'h0FF});
        end
        last_res = 9'h0FF;
        tick();
    endtask

    // Next start is issued in the IDLE cycle right after each done, so done
    // appearing exactly in cycle W+1 of every operation pins spacing to W+2.
    task automatic test_back_to_back();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   exp;
        for (int n = 0; n < 1000; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            exp = ref_add(ra, rb);
            do_start(ra, rb);
            for (int c = 1; c <= W; c++) begin
                n_cmp++;
                if ({busy, done, carry, sum} !== {2'b10, last_res}) begin
                    n_err++;
                    $display("FAIL rand_run n%0d c%0d: busy,done,carry,sum=%h required %h",
                             n, c, {busy, done, carry, sum}, {2'b10, last_res});
                end
                // Operands and start wander while busy; none of it may matter.
                a     = W'($urandom);
                b     = W'($urandom);
                start = 1'($urandom_range(0, 1));
                tick();
            end
            n_cmp++;
            if ({busy, done, carry, sum} !== {2'b01, exp}) begin
                n_err++;
                $display("FAIL rand_done n%0d a=%h b=%h: busy,done,carry,sum=%h required %h",
                         n, ra, rb, {busy, done, carry, sum}, {2'b01, exp});
            end
            last_res = exp;
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            tick();
            start = 1'b0;
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_err++;
                $display("FAIL rand_idle n%0d: busy,done=%b required 00", n, {busy, done});
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; last_res = '0;
        test_reset();
        test_basic_wrap();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder; the additive counterpart of the team's combinational subtractor cells.
- Operands are loaded in parallel on a start request and added LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Sum and carry-out are presented in parallel with a one-cycle done pulse.
- Used in area-constrained datapaths where one adder bit-slice is time-shared across a word.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1 to 32).

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  first operand; captured in the cycle start is accepted.
- B  input  WIDTH  second operand; captured in the cycle start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum and carry become valid.
- sum  output  WIDTH  registered result (A+B) mod 2^WIDTH.
- carry  output  1  registered carry-out of the MSB.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: while rst is high at a rising edge, all state is cleared at that edge.
  - busy=0, done=0, sum=0, carry=0.
  - FSM goes to IDLE.
  - Internal shift registers, carry flip-flop and bit counter go to 0.
  - rst has priority over start and over any in-progress operation. Reset mid-operation aborts the addition with no done pulse, and sum/carry read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: A and B are loaded into the operand shift registers, the internal result shift register is cleared, the carry flip-flop is cleared, counter=0, and the FSM moves to RUN.
  - If start=0, the FSM stays in IDLE.
- RUN:
  - busy=1, done=0.
  - Each edge: full_adder(a_sr[0], b_sr[0], cff) is evaluated.
  - The sum bit shifts into the MSB of the result shift register (right shift); a_sr and b_sr shift right.
  - cff takes the full-adder cout, and the counter increments.
  - At the edge where counter==WIDTH-1: the final sum bit is shifted in, sum and carry are loaded from the completed result register and cout, and the FSM moves to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge moves to IDLE unconditionally.
- Latency: with start accepted at edge 0, busy is high for cycles 1..WIDTH. done is high in cycle WIDTH+1, and sum/carry are valid from that cycle on.
- Hold: sum and carry hold the previous result throughout RUN. They change only at the completing edge or on reset.
- start while busy, or in the DONE cycle, is ignored. Such a request is not queued.
- A and B may change freely after the accepting edge without affecting the result.
- Arithmetic: {carry,sum} == A + B as an unsigned (WIDTH+1)-bit value. Wrap-around is reported only via carry.
- WIDTH=1: RUN lasts exactly one cycle; the behaviour is otherwise identical.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE), 2 bits;
  - constant DEFAULT_WIDTH=8;
  - counter width function CNT_W(WIDTH) = clog2(WIDTH) (minimum 1).
- One sub-module, full_adder: combinational, inputs a, b, cin; outputs s = a^b^cin and cout = ab | cin(a^b).
- The FSM, shift registers and counter live in serial_adder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=0, done=0, sum=0x00, carry=0 held indefinitely.
- Basic add, WIDTH=8: A=0x3C, B=0x05, start pulse -> busy high 8 cycles; done in cycle 9 with sum=0x41, carry=0.
- Wrap-around and carry: A=0xFF, B=0x01 -> sum=0x00, carry=1. Then A=0xFF, B=0xFF -> sum=0xFE, carry=1. Each gets exactly one done pulse, and the prior result is held during RUN.
- Ignored starts: A=0x10, B=0x20 started; start re-asserted with A=0x77 in cycles 3 and 9 (DONE) -> single done, sum=0x30. A new start in the following IDLE cycle with A=0x77, B=0x01 -> sum=0x78.
- Reset mid-operation: start A=0xAA, B=0x55; rst=1 in cycle 4 -> busy=0, no done, sum=0x00, carry=0. A fresh start then gives sum=0xFF, carry=0 with normal latency.
- Randomized check: 1000 random A/B pairs, back-to-back starts issued in IDLE -> {carry,sum} equals A+B every time, and done spacing is WIDTH+2 cycles.
